// File: rtl/correlator_engine_if.sv
// correlator_engine_if
//   Bundles the load port, run request and result signals of the correlator.
//   Parameters:
//     DATA_W, ADDR_W, ACC_W : must match the correlator_engine instance.
//   Signals:
//     load_we / load_sel / load_addr / load_data : sample memory write port
//     start / n_samples / lag                    : run request
//     busy / done / result / overflow            : run status and result
//   Modports:
//     master : loader / controller side (drives the requests)
//     slave  : the correlator engine
interface correlator_engine_if #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 4,
    parameter int ACC_W  = 16
) ();
    logic              load_we;
    logic              load_sel;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;
    logic              start;
    logic [ADDR_W:0]   n_samples;
    logic [ADDR_W-1:0] lag;
    logic              busy;
    logic              done;
    logic [ACC_W-1:0]  result;
    logic              overflow;

    modport master (
        output load_we, load_sel, load_addr, load_data,
        output start, n_samples, lag,
        input  busy, done, result, overflow
    );

    modport slave (
        input  load_we, load_sel, load_addr, load_data,
        input  start, n_samples, lag,
        output busy, done, result, overflow
    );
endinterface

// File: rtl/correlator_engine.sv
// correlator_engine
//   Sum-of-products correlator over two sample memories A and B:
//     P = sum_{k=0}^{n_eff-1} A[k] * B[(k + lag) mod DEPTH]
//   one MAC per clock, saturating accumulator.
//   Optional build macro: CORR_SIGNED_EN -- two's complement samples with
//   signed saturation; otherwise unsigned with all-ones saturation.
//   Ports:
//     clk   : rising-edge clock
//     reset : synchronous, active-high reset
//     bus   : correlator_engine_if.slave (load port, start/n_samples/lag,
//             busy/done/result/overflow)
//
//   state  | meaning
//   IDLE   | waiting for start; memory writes accepted
//   RUN    | one MAC per cycle, busy=1, memory writes dropped
//   DONE   | one-cycle done pulse, result/overflow valid
module correlator_engine #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int ACC_W  = 16
) (
    input logic               clk,
    input logic               reset,
    correlator_engine_if.slave bus
);

    localparam logic [ADDR_W:0] DEPTH_N = (ADDR_W+1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            state;
    state_t            state_nxt;

    logic [DATA_W-1:0] mem_a [DEPTH];
    logic [DATA_W-1:0] mem_b [DEPTH];

    logic [ADDR_W:0]   n_eff;
    logic [ADDR_W:0]   n_lat;
    logic [ADDR_W-1:0] lag_lat;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] b_idx;
    logic [DATA_W-1:0] a_rd;
    logic [DATA_W-1:0] b_rd;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_nxt;
    logic [ACC_W:0]    sum;
    logic              ovf;
    logic              ovf_step;
    logic              last_mac;
    logic [ACC_W-1:0]  result_q;
    logic              overflow_q;

    always_comb n_eff = (bus.n_samples > DEPTH_N) ? DEPTH_N : bus.n_samples;

    // ADDR_W-bit add: the carry is dropped so the B index wraps mod DEPTH
    always_comb b_idx = idx + lag_lat;
    always_comb a_rd  = mem_a[idx];
    always_comb b_rd  = mem_b[b_idx];

    always_comb last_mac = ({1'b0, idx} == (n_lat - 1'b1));

`ifdef CORR_SIGNED_EN
    logic signed [2*DATA_W-1:0] prod;

    always_comb begin
        prod = $signed(a_rd) * $signed(b_rd);
        sum  = {acc[ACC_W-1], acc}
             + {{(ACC_W+1-2*DATA_W){prod[2*DATA_W-1]}}, prod};
        // extra top bit disagreeing with the result sign bit means overflow
        ovf_step = sum[ACC_W] ^ sum[ACC_W-1];
        if (ovf_step)
            acc_nxt = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                 : {1'b0, {(ACC_W-1){1'b1}}};
        else
            acc_nxt = sum[ACC_W-1:0];
    end
`else
    logic [2*DATA_W-1:0] prod;

    always_comb begin
        prod     = a_rd * b_rd;
        sum      = {1'b0, acc} + {{(ACC_W+1-2*DATA_W){1'b0}}, prod};
        ovf_step = sum[ACC_W];
        acc_nxt  = ovf_step ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
    end
`endif

    always_ff @(posedge clk) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        bus.busy  = 1'b0;
        bus.done  = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start)
                    state_nxt = (n_eff == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                bus.busy = 1'b1;
                if (last_mac)
                    state_nxt = S_DONE;
            end
            S_DONE: begin
                bus.done  = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc        <= '0;
            idx        <= '0;
            n_lat      <= '0;
            lag_lat    <= '0;
            ovf        <= 1'b0;
            result_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        n_lat   <= n_eff;
                        lag_lat <= bus.lag;
                        acc     <= '0;
                        idx     <= '0;
                        ovf     <= 1'b0;
                        if (n_eff == '0) begin
                            result_q   <= '0;
                            overflow_q <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    acc <= acc_nxt;
                    idx <= idx + 1'b1;
                    ovf <= ovf | ovf_step;
                    // result is loaded on the edge entering DONE so it is
                    // already valid while done is high
                    if (last_mac) begin
                        result_q   <= acc_nxt;
                        overflow_q <= ovf | ovf_step;
                    end
                end
                default: ;
            endcase
        end
    end

    // Memories are not reset; writes are dropped while a run is in progress.
    always_ff @(posedge clk) begin
        if (bus.load_we && (state != S_RUN)) begin
            if (bus.load_sel)
                mem_b[bus.load_addr] <= bus.load_data;
            else
                mem_a[bus.load_addr] <= bus.load_data;
        end
    end

    assign bus.result   = result_q;
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_correlator_engine.sv
// tb_correlator_engine
//   Drives two correlator instances (ACC_W=16 and ACC_W=8) with identical
//   stimulus. Expected results come from a behavioural model of the memories
//   and are queued at start, then popped when each instance pulses done.
module tb_correlator_engine;

    localparam int DATA_W = 4;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    typedef struct {
        longint res;
        bit     ov;
        int     cyc;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   total;
    int   bad;
    int   done_m;
    int   done_s;
    int   ma [DEPTH];
    int   mb [DEPTH];
    exp_t q_m [$];
    exp_t q_s [$];
    longint last_m;
    longint last_s;

    correlator_engine_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ACC_W(16)) bus_m ();
    correlator_engine_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ACC_W(8))  bus_s ();

    correlator_engine #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .ACC_W(16)) dut_m (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_m)
    );

    correlator_engine #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .ACC_W(8)) dut_s (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check_val(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic longint sx(input int v);
`ifdef CORR_SIGNED_EN
        return (v >= 8) ? longint'(v - 16) : longint'(v);
`else
        return longint'(v);
`endif
    endfunction

    function automatic void model(input int n, input int lg, input int accw,
                                  output longint res, output bit ov);
        longint acc, mx, mn;
        int     neff;
        neff = (n > DEPTH) ? DEPTH : n;
        acc  = 0;
        ov   = 1'b0;
`ifdef CORR_SIGNED_EN
        mx = (longint'(1) << (accw - 1)) - 1;
        mn = -(longint'(1) << (accw - 1));
`else
        mx = (longint'(1) << accw) - 1;
        mn = 0;
`endif
        for (int k = 0; k < neff; k++) begin
            acc = acc + sx(ma[k]) * sx(mb[(k + lg) % DEPTH]);
            if (acc > mx) begin
                acc = mx;
                ov  = 1'b1;
            end else if (acc < mn) begin
                acc = mn;
                ov  = 1'b1;
            end
        end
        res = acc & ((longint'(1) << accw) - 1);
    endfunction

    always @(negedge clk) begin : mon_m
        exp_t e;
        if (!reset && bus_m.done) begin
            done_m++;
            if (q_m.size() == 0) begin
                check_val("m_spurious_done", 1, 0);
            end else begin
                e = q_m.pop_front();
                check_val("m_result", bus_m.result, e.res);
                check_val("m_overflow", bus_m.overflow, e.ov);
                check_val("m_latency", cyc, e.cyc);
                check_val("m_busy_in_done", bus_m.busy, 0);
            end
        end
    end

    always @(negedge clk) begin : mon_s
        exp_t e;
        if (!reset && bus_s.done) begin
            done_s++;
            if (q_s.size() == 0) begin
                check_val("s_spurious_done", 1, 0);
            end else begin
                e = q_s.pop_front();
                check_val("s_result", bus_s.result, e.res);
                check_val("s_overflow", bus_s.overflow, e.ov);
                check_val("s_latency", cyc, e.cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_load(input bit we, input bit sel, input int addr, input int data);
        bus_m.load_we   = we;
        bus_m.load_sel  = sel;
        bus_m.load_addr = 4'(addr);
        bus_m.load_data = 4'(data);
        bus_s.load_we   = we;
        bus_s.load_sel  = sel;
        bus_s.load_addr = 4'(addr);
        bus_s.load_data = 4'(data);
    endtask

    task automatic drive_run(input bit st, input int n, input int lg);
        bus_m.start     = st;
        bus_m.n_samples = 5'(n);
        bus_m.lag       = 4'(lg);
        bus_s.start     = st;
        bus_s.n_samples = 5'(n);
        bus_s.lag       = 4'(lg);
    endtask

    // write one sample to both instances and the model (call only when idle)
    task automatic write_mem(input bit sel, input int addr, input int data);
        drive_load(1'b1, sel, addr, data);
        tick();
        drive_load(1'b0, 1'b0, 0, 0);
        if (sel) mb[addr] = data;
        else     ma[addr] = data;
    endtask

    task automatic fill(input int a_val, input int b_val);
        for (int i = 0; i < DEPTH; i++) begin
            write_mem(1'b0, i, a_val);
            write_mem(1'b1, i, b_val);
        end
    endtask

    task automatic launch(input int n, input int lg);
        exp_t em, es;
        int   neff;
        neff = (n > DEPTH) ? DEPTH : n;
        model(n, lg, 16, em.res, em.ov);
        model(n, lg, 8, es.res, es.ov);
        em.cyc = cyc + neff + 1;
        es.cyc = cyc + neff + 1;
        q_m.push_back(em);
        q_s.push_back(es);
        last_m = em.res;
        last_s = es.res;
        drive_run(1'b1, n, lg);
        tick();
        drive_run(1'b0, n, lg);
    endtask

    task automatic wait_done(input int target_m, input int target_s);
        for (int i = 0; i < 60; i++) begin
            if (done_m >= target_m && done_s >= target_s) break;
            tick();
        end
        check_val("done_seen", (done_m >= target_m && done_s >= target_s), 1);
    endtask

    task automatic run(input int n, input int lg);
        int tm, ts;
        tm = done_m + 1;
        ts = done_s + 1;
        launch(n, lg);
        wait_done(tm, ts);
        tick();
        check_val("m_hold", bus_m.result, last_m);
        check_val("s_hold", bus_s.result, last_s);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin : stim
        int tm, ts, a0;
        total  = 0;
        bad    = 0;
        done_m = 0;
        done_s = 0;
        reset  = 1'b1;
        drive_load(1'b0, 1'b0, 0, 0);
        drive_run(1'b0, 0, 0);
        repeat (3) tick();
        reset = 1'b0;
        tick();

        check_val("rst_busy", bus_m.busy, 0);
        check_val("rst_done", bus_m.done, 0);
        check_val("rst_result", bus_m.result, 0);
        check_val("rst_overflow", bus_m.overflow, 0);
        check_val("rst_s_result", bus_s.result, 0);

        // ramp 0..3, no lag then lag 1
        fill(0, 0);
        for (int i = 0; i < 4; i++) begin
            write_mem(1'b0, i, i);
            write_mem(1'b1, i, i);
        end
        run(4, 0);
        run(4, 1);

        // lag wrap: A[15]*B[0]
        fill(0, 0);
        write_mem(1'b0, 15, 2);
        write_mem(1'b1, 0, 3);
        run(16, 1);

        // zero count (result forced to 0 after a nonzero result)
        run(0, 0);

        // clamped count
        fill(1, 1);
        run(31, 0);

        // saturation on the narrow instance, then a short clean run
        fill(15, 15);
        run(16, 0);
        run(1, 0);

        // random data and parameters
        for (int i = 0; i < DEPTH; i++) begin
            write_mem(1'b0, i, $urandom_range(0, 15));
            write_mem(1'b1, i, $urandom_range(0, 15));
        end
        for (int r = 0; r < 4; r++)
            run($urandom_range(0, 20), $urandom_range(0, 15));

        // start pulsed mid-run: single done only
        tm = done_m + 1;
        ts = done_s + 1;
        launch(12, 3);
        tick();
        tick();
        drive_run(1'b1, 5, 0);
        tick();
        drive_run(1'b0, 5, 0);
        wait_done(tm, ts);
        repeat (25) tick();
        check_val("single_done_m", done_m, tm);
        check_val("single_done_s", done_s, ts);

        // load mid-run is dropped: a repeat run sees unchanged memories
        launch(16, 2);
        tm = done_m + 1;
        ts = done_s + 1;
        tick();
        tick();
        a0 = ma[0] ^ 15;
        drive_load(1'b1, 1'b0, 0, a0);
        tick();
        drive_load(1'b1, 1'b1, 2, a0);
        tick();
        drive_load(1'b0, 1'b0, 0, 0);
        wait_done(tm, ts);
        run(16, 2);

        // reset on cycle 3 of a run: abort, no done, memories retained
        tm = done_m;
        ts = done_s;
        drive_run(1'b1, 16, 0);
        tick();
        drive_run(1'b0, 16, 0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_val("abort_busy", bus_m.busy, 0);
        check_val("abort_result", bus_m.result, 0);
        check_val("abort_s_result", bus_s.result, 0);
        check_val("abort_overflow", bus_s.overflow, 0);
        repeat (25) tick();
        check_val("abort_no_done_m", done_m, tm);
        check_val("abort_no_done_s", done_s, ts);
        run(16, 0);

        check_val("queue_empty_m", q_m.size(), 0);
        check_val("queue_empty_s", q_s.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/correlator_engine.md
Name: correlator_engine

Overview:
- Parametrised sum-of-products correlation engine over two writable sample memories, A and B.
- Computes P = sum over k=0..N-1 of A[k] * B[(k+lag) mod DEPTH], one multiply-accumulate (MAC) per clock.
- Sample count and lag are run-time selectable; start/busy/done handshake; saturating accumulator.
- Sits between the sample loader and the display/readout logic, replacing the fixed 4-bit, 4-sample, zero-lag correlator.

Parameters:
- DATA_W, 4, sample width in bits (unsigned unless CORR_SIGNED_EN).
- DEPTH, 16, entries per memory; power of two, at least 2.
- ADDR_W, 4, log2(DEPTH).
- ACC_W, 16, accumulator/result width; at least 2*DATA_W.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- load_we  in  1  memory write strobe
- load_sel  in  1  0 = write memory A, 1 = write memory B
- load_addr  in  ADDR_W  write address
- load_data  in  DATA_W  write data
- start  in  1  begin a correlation run (level sampled in IDLE)
- n_samples  in  ADDR_W+1  requested sample count
- lag  in  ADDR_W  B-index offset
- busy  out  1  run in progress
- done  out  1  one-cycle pulse: result updated
- result  out  ACC_W  last completed sum, held until next done
- overflow  out  1  last run saturated

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (reset).
- Reset: state IDLE; busy=0, done=0, result=0, overflow=0; accumulator and index cleared. Memory contents are not cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN on an edge with start=1 and n_eff>0:
  - n_eff = min(n_samples, DEPTH);
  - latch n_eff and lag; acc=0; idx=0; ovf=0; busy=1 from this edge.
- IDLE -> DONE directly if start=1 and n_eff=0. Result becomes 0.
- RUN, each cycle:
  - acc += A[idx] * B[(idx+lag_latched) mod DEPTH]; idx++;
  - after the n_eff-th MAC go to DONE.
  - Memory reads are combinational from the register arrays.
- DONE (one cycle):
  - done=1, busy=0; result=acc, overflow=ovf both valid this cycle and held afterwards;
  - next state IDLE. A start seen in DONE is ignored.
- Latency: start edge to done high = n_eff+1 cycles (1 cycle when n_eff=0).
- Arithmetic:
  - product width is 2*DATA_W, zero-extended to ACC_W+1 before the add;
  - if the sum exceeds 2^ACC_W-1, acc = all ones and ovf=1 (sticky for the run).
- Lag index wraps modulo DEPTH (ADDR_W-bit add, carry discarded).
- start while busy or in DONE: ignored. No queuing.
- load_we while busy=1: write dropped, so memories are stable during a run. Writes in IDLE/DONE take effect next cycle.
- n_samples and lag changing mid-run: no effect (values are latched).
- reset mid-run: abort immediately to the reset state; no done pulse.

Optional Feature:
- CORR_SIGNED_EN defined:
  - samples are two's complement; products are sign-extended;
  - accumulator is signed and saturates to +(2^(ACC_W-1)-1) or -(2^(ACC_W-1)), setting overflow.
- CORR_SIGNED_EN undefined: unsigned arithmetic and all-ones saturation, as above.

Test Plan:
- Ramp, no lag: A[i]=B[i]=i for i=0..3, rest 0; n_samples=4, lag=0, start -> done 5 cycles after start, result=14, overflow=0.
- Lag: same data; lag=1, n_samples=4 -> result=0*1+1*2+2*3+3*0=8.
- Lag wrap: A[15]=2, B[0]=3, all else 0; n_samples=16, lag=1 -> result=6.
- Zero and clamped counts:
  - n_samples=0 -> done 1 cycle after start, result=0;
  - n_samples=31 with all A=B=1 -> clamped to 16, result=16.
- Saturation (ACC_W=8 override): all A=B=15, n_samples=16 -> result=255, overflow=1. The next run with n_samples=1 gives result=225, overflow=0.
- Protocol:
  - start pulsed mid-run -> no restart, single done;
  - load_we mid-run -> memory unchanged;
  - reset asserted on cycle 3 of a run -> busy=0, result=0, no done, memories retain data.
